// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - drains a show-ahead FIFO into a valid/ready stream in bursts
// Optional build macro: FIFO_DRAIN_STATS_EN (enables the words_sent handshake counter).
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 128,
    parameter int BURST_LEN  = 64,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    output logic                  fifo_rd_en,
    output logic                  s_out_valid,
    input  logic                  s_out_rdy,
    output logic [DATA_WIDTH-1:0] s_out_data,
    output logic                  busy,
    output logic [31:0]           words_sent
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [16:0] BURST_LEN_W = 17'(BURST_LEN);
    localparam logic [16:0] TIMEOUT_W   = 17'(TIMEOUT);

    state_t                state;
    logic [15:0]           idle_cnt;
    logic [15:0]           beat_cnt;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;
    logic                  pop;
    logic                  last_beat;
    logic                  trigger;

    // Reads depend only on registered occupancy, never on s_out_rdy.
    assign fifo_rd_en  = (state == BURST) && !fifo_empty && (occ != 2'd2);
    assign s_out_valid = (occ != 2'd0);
    assign s_out_data  = buf_head;
    assign busy        = (state == BURST);
    assign pop         = s_out_valid && s_out_rdy;
    assign last_beat   = fifo_rd_en && (({1'b0, beat_cnt} + 17'd1) == BURST_LEN_W);
    assign trigger     = !fifo_empty &&
                         (!fifo_almostempty || ({1'b0, idle_cnt} >= TIMEOUT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idle_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= BURST;
                        idle_cnt <= '0;
                        beat_cnt <= '0;
                    end else if (fifo_empty) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != 16'hFFFF) begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                BURST: begin
                    if (fifo_rd_en)
                        beat_cnt <= beat_cnt + 16'd1;
                    if (fifo_empty || last_beat)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; head is always the oldest word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            occ <= occ + {1'b0, fifo_rd_en} - {1'b0, pop};
            if (pop) begin
                if (occ == 2'd2)
                    buf_head <= buf_tail;
                else if (fifo_rd_en)
                    buf_head <= fifo_dout;
            end else if (fifo_rd_en) begin
                if (occ == 2'd0)
                    buf_head <= fifo_dout;
                else
                    buf_tail <= fifo_dout;
            end
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] sent_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sent_cnt <= '0;
        else if (pop)
            sent_cnt <= sent_cnt + 32'd1;
    end

    assign words_sent = sent_cnt;
`else
    assign words_sent = '0;
`endif

endmodule

// File: doc/fifo_stream_drain.md
# fifo_stream_drain

Read-side companion to the team's show-ahead FIFO wrapper: pulls words out of a show-ahead FIFO and presents them as a Pico valid/ready output stream. Batches reads into bursts, triggered either by FIFO fill level (almost-empty deasserted) or by an idle timeout, so downstream PCIe/stream logic sees dense transfers. A 2-entry output buffer decouples `s_out_rdy` from `fifo_rd_en`, leaving no combinational path between the two.

## Interface
Parameters:
- `DATA_WIDTH`, 128: word width of the FIFO and the stream.
- `BURST_LEN`, 64: maximum FIFO reads per burst; legal range 1..65535.
- `TIMEOUT`, 256: idle cycles with FIFO non-empty before a forced burst; 0 = start a burst as soon as the FIFO is non-empty; legal range 0..65535.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset: asynchronous assert, active-high.
- `fifo_dout`  in  DATA_WIDTH  show-ahead FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_almostempty`  in  1  FIFO at or below its almost-empty level.
- `fifo_rd_en`  out  1  pop the FIFO head this cycle.
- `s_out_valid`  out  1  stream word valid.
- `s_out_rdy`  in  1  downstream accepts the word.
- `s_out_data`  out  DATA_WIDTH  stream word.
- `busy`  out  1  high while in BURST.
- `words_sent`  out  32  count of completed stream handshakes; see Configuration.

## Operation
- States: IDLE, BURST. Reset state is IDLE.
- IDLE -> BURST when `fifo_empty`=0 and either `fifo_almostempty`=0 or `idle_cnt` >= `TIMEOUT`.
- `idle_cnt` (16 bit, saturating) increments each IDLE cycle with `fifo_empty`=0. It clears when `fifo_empty`=1 or on entry to BURST.
- In BURST: `fifo_rd_en` = (`fifo_empty`=0) AND (`occ` < 2). Each read increments `beat_cnt`; `beat_cnt` clears on entry to BURST.
- BURST -> IDLE on the cycle after the read that makes `beat_cnt` = `BURST_LEN`. BURST -> IDLE also on any BURST cycle with `fifo_empty`=1.
- `fifo_rd_en` is 0 in IDLE. It is a combinational function of state, `occ` and `fifo_empty` only, never of `s_out_rdy`.
- Output buffer: 2-entry FIFO with occupancy `occ` (0..2). A word read from the FIFO is written to the tail at the clock edge.
- `occ_next` = `occ` + `fifo_rd_en` − (`s_out_valid` & `s_out_rdy`). A simultaneous read and handshake at `occ`=1 holds `occ` at 1.
- `s_out_valid` = (`occ` != 0). `s_out_data` is the head entry and is held stable while `s_out_valid`=1 and `s_out_rdy`=0.
- Words leave in exact FIFO order. No word is dropped or duplicated.
- Stream-side draining continues in IDLE until `occ`=0. Only FIFO reads are gated by state.
- Reset mid-operation: the buffer contents are discarded, `occ`=0, state returns to IDLE, and counters clear. Words already popped from the FIFO are lost. This is accepted.

## Timing
- Reset values: `s_out_valid`=0, `fifo_rd_en`=0, `busy`=0, `words_sent`=0, `s_out_data`=0.
- Latency: a FIFO read in cycle N places the word on `s_out_data` with `s_out_valid`=1 in cycle N+1.
- Trigger latency: `busy` rises one cycle after the IDLE->BURST condition is sampled true. The first `fifo_rd_en` is in that same cycle.
- Sustained throughput: 1 word/cycle while `s_out_rdy`=1 and the FIFO stays non-empty.
- Backpressure: with `s_out_rdy`=0, at most 2 further reads happen, then `fifo_rd_en` stays 0.
- `fifo_empty` rising in BURST: no read occurs that cycle, and `busy` falls on the next edge.

## Configuration
- Macro: `FIFO_DRAIN_STATS_EN`.
- When defined: `words_sent` is a 32-bit register incremented on every `s_out_valid` & `s_out_rdy` cycle. It wraps 0xFFFFFFFF -> 0 and clears on `rst`.
- When undefined: `words_sent` is tied to 0 and no counter logic is built.
- Datapath behaviour is identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-burst with `occ`=2 -> all outputs read 0 immediately; after release, state is IDLE and `occ`=0.
- Level trigger: `BURST_LEN`=64; preload 200 words, so `fifo_almostempty`=0; hold `s_out_rdy`=1 -> exactly 64 consecutive `fifo_rd_en` pulses, then `busy` falls; a new burst follows; output order matches 0..199.
- Timeout trigger: `TIMEOUT`=10; preload 3 words, so `fifo_almostempty`=1 -> the first `fifo_rd_en` occurs 11 cycles after `fifo_empty` falls; 3 words are sent; `busy` falls when `fifo_empty` rises.
- Backpressure: hold `s_out_rdy`=0 during a burst -> exactly 2 reads, then `fifo_rd_en`=0 and `s_out_data` stays stable; release `s_out_rdy` -> full rate resumes with no loss.
- Random `s_out_rdy` (50%) over 10,000 words -> scoreboard exact order; `occ` never exceeds 2; the FIFO is never read while empty.
- Stats: with `FIFO_DRAIN_STATS_EN`, preload `words_sent` near 0xFFFFFFFE by force and send 3 words -> reads 1. Without the macro -> constant 0.
